// File: rtl/seg7_scan_decoder.sv
// ---------------------------------------------------------------------------
// seg7_scan_decoder
//
// Receive side of a 3-digit multiplexed 7-segment display. Watches the
// segment and digit-select lines, samples each digit once its select line
// has been steady long enough, decodes the segment pattern back to BCD and,
// after units, tens and hundreds have all been captured, rebuilds the 8-bit
// binary value with a short shift-and-add sequence.
//
// Parameters
//   SETTLE_CYCLES  cycles a digit select must be stable before sampling (4..65535)
//   SEG_ACTIVE_LOW 1 = segment lit when its line is 0
//   DIG_ACTIVE_LOW 1 = digit selected when its line is 0
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   seg_in[6:0]  segment lines, bit0=A .. bit6=G
//   dig_sel[2:0] digit selects, bit0=units, bit1=tens, bit2=hundreds
//   value_out    last good decoded binary value
//   digits_out   BCD of value_out: [11:8] hundreds, [7:4] tens, [3:0] units
//   value_valid  1-cycle pulse when value_out/digits_out update
//   frame_err    1-cycle pulse when a completed frame is rejected
// ---------------------------------------------------------------------------

// Per-digit capture slot: holds the decoded nibble, its bad flag and the
// "captured this frame" mask bit. One instance per display digit.
module seg7_digit_slot (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,    // drop the mask bit (frame consumed)
  input  logic       wr,     // capture bcd/bad into this slot
  input  logic [3:0] bcd,
  input  logic       bad,
  output logic [3:0] bcd_q,
  output logic       bad_q,
  output logic       have_q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_q  <= 4'h0;
      bad_q  <= 1'b0;
      have_q <= 1'b0;
    end else begin
      // A recapture before the frame completes simply overwrites.
      if (wr) begin
        bcd_q <= bcd;
        bad_q <= bad;
      end
      if (clr)     have_q <= 1'b0;
      else if (wr) have_q <= 1'b1;
    end
  end

endmodule

module seg7_scan_decoder #(
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg_in,
  input  logic [2:0]  dig_sel,
  output logic [7:0]  value_out,
  output logic [11:0] digits_out,
  output logic        value_valid,
  output logic        frame_err
);

  localparam int          NUM_DIGITS = 3;
  localparam int          CNT_W      = 16;
  localparam logic [CNT_W-1:0] SETTLE    = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] SETTLE_M1 = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {COLLECT, MUL, ADD, DONE} state_t;

  // -------------------------------------------------------------------------
  // Input stage: register once and normalise to 1 = lit / selected.
  // -------------------------------------------------------------------------
  logic [6:0]            seg_r;
  logic [NUM_DIGITS-1:0] dig_r;
  logic [NUM_DIGITS-1:0] dig_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_r <= '0;
      dig_r <= '0;
    end else begin
      seg_r <= SEG_ACTIVE_LOW ? ~seg_in  : seg_in;
      dig_r <= DIG_ACTIVE_LOW ? ~dig_sel : dig_sel;
    end
  end

  // -------------------------------------------------------------------------
  // Digit qualification. The counter only runs while the registered select
  // is one-hot and unchanged; it saturates so each strobe samples once.
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] settle_cnt;
  logic             dig_onehot;
  logic             dig_stable;
  logic             sample;

  assign dig_onehot = (dig_r != '0) && ((dig_r & (dig_r - 3'd1)) == '0);
  assign dig_stable = dig_onehot && (dig_r == dig_prev);
  // Requiring an unchanged select here keeps a one-hot-to-one-hot switch
  // from sampling on the very cycle the counter is being cleared.
  assign sample     = dig_stable && (settle_cnt == SETTLE_M1);

  always_ff @(posedge clk) begin
    if (rst) begin
      dig_prev   <= '0;
      settle_cnt <= '0;
    end else begin
      dig_prev <= dig_r;
      if (!dig_stable)
        settle_cnt <= '0;
      else if (settle_cnt != SETTLE)
        settle_cnt <= settle_cnt + CNT_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Segment decode of the registered pattern ({G,F,E,D,C,B,A}).
  // 0x67 is the "no tail" 9; a blanked digit reads as 0.
  // -------------------------------------------------------------------------
  logic [3:0] dec_bcd;
  logic       dec_bad;

  always_comb begin
    dec_bcd = 4'hF;
    dec_bad = 1'b0;
    unique case (seg_r)
      7'h3F:   dec_bcd = 4'd0;
      7'h06:   dec_bcd = 4'd1;
      7'h5B:   dec_bcd = 4'd2;
      7'h4F:   dec_bcd = 4'd3;
      7'h66:   dec_bcd = 4'd4;
      7'h6D:   dec_bcd = 4'd5;
      7'h7D:   dec_bcd = 4'd6;
      7'h07:   dec_bcd = 4'd7;
      7'h7F:   dec_bcd = 4'd8;
      7'h6F:   dec_bcd = 4'd9;
      7'h67:   dec_bcd = 4'd9;
      7'h00:   dec_bcd = 4'd0;
      default: dec_bad = 1'b1;
    endcase
  end

  // -------------------------------------------------------------------------
  // Capture slots, one per digit.
  // -------------------------------------------------------------------------
  state_t                      state;
  logic [NUM_DIGITS-1:0]       slot_wr;
  logic [NUM_DIGITS-1:0][3:0]  slot_bcd;
  logic [NUM_DIGITS-1:0]       slot_bad;
  logic [NUM_DIGITS-1:0]       slot_have;
  logic                        slot_clr;

  // Captures outside COLLECT are dropped.
  assign slot_wr  = (sample && (state == COLLECT)) ? dig_r : '0;
  assign slot_clr = (state == MUL);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_slot
      seg7_digit_slot u_slot (
        .clk    (clk),
        .rst    (rst),
        .clr    (slot_clr),
        .wr     (slot_wr[gi]),
        .bcd    (dec_bcd),
        .bad    (dec_bad),
        .bcd_q  (slot_bcd[gi]),
        .bad_q  (slot_bad[gi]),
        .have_q (slot_have[gi])
      );
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Reconstruction arithmetic. x*100 = x<<6 + x<<5 + x<<2, x*10 = x<<3 + x<<1.
  // Nine hundreds plus 99 is 999, which still fits the 10-bit accumulator.
  // -------------------------------------------------------------------------
  logic [9:0] h_ext, t_ext, u_ext;
  logic [9:0] hund_x100;
  logic [9:0] acc;
  logic [9:0] acc_sum;
  logic       frame_good;

  assign h_ext     = {6'd0, slot_bcd[2]};
  assign t_ext     = {6'd0, slot_bcd[1]};
  assign u_ext     = {6'd0, slot_bcd[0]};
  assign hund_x100 = (h_ext << 6) + (h_ext << 5) + (h_ext << 2);
  assign acc_sum   = acc + (t_ext << 3) + (t_ext << 1) + u_ext;
  assign frame_good = (slot_bad == '0) && (acc_sum <= 10'd255);

  // -------------------------------------------------------------------------
  // Frame FSM. The result is judged on the ADD->DONE edge so the outputs are
  // registered and present while the FSM sits in DONE; that puts the pulse
  // three edges after the final capture.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= COLLECT;
      acc         <= '0;
      value_out   <= '0;
      digits_out  <= '0;
      value_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      value_valid <= 1'b0;
      frame_err   <= 1'b0;
      unique case (state)
        COLLECT: begin
          if (&slot_have) state <= MUL;
        end
        MUL: begin
          acc   <= hund_x100;
          state <= ADD;
        end
        ADD: begin
          acc <= acc_sum;
          if (frame_good) begin
            value_out   <= acc_sum[7:0];
            digits_out  <= {slot_bcd[2], slot_bcd[1], slot_bcd[0]};
            value_valid <= 1'b1;
          end else begin
            frame_err   <= 1'b1;
          end
          state <= DONE;
        end
        DONE: begin
          state <= COLLECT;
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receive-side counterpart of the 3-digit multiplexed 7-segment display driver.
- Watches the segment lines and the digit-select lines, samples each digit once its strobe has settled, and decodes each pattern back to BCD.
- Once units, tens and hundreds are all captured, reconstructs the 8-bit binary value with a short sequential multiply-add.
- Used for loopback self-test of the display path and for reading a scanned display into the counter domain.

Parameters:
- SETTLE_CYCLES, 16: cycles a digit select must stay stable before its segments are sampled; legal range 4..65535.
- SEG_ACTIVE_LOW, 1: 1 = a segment is lit when its line is 0.
- DIG_ACTIVE_LOW, 1: 1 = a digit is selected when its line is 0.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- seg_in  in  7  segment lines, bit0=A … bit6=G. Decimal point is not an input.
- dig_sel  in  3  digit selects: bit0=units, bit1=tens, bit2=hundreds.
- value_out  out  8  last successfully decoded binary value.
- digits_out  out  12  BCD of that value: [11:8] hundreds, [7:4] tens, [3:0] units.
- value_valid  out  1  one-cycle pulse when value_out/digits_out update.
- frame_err  out  1  one-cycle pulse when a completed frame is rejected.

Behaviour:
- Reset (rst=1 at an edge):
  - value_out=0, digits_out=0, value_valid=0, frame_err=0.
  - Capture mask cleared, FSM=COLLECT, settle counter=0, input registers=0.
  - Reset mid-conversion aborts the conversion; no pulse is produced.
- Input stage:
  - seg_in and dig_sel are registered once.
  - Both are polarity-normalised so that 1 = lit / selected.
- Digit qualification:
  - Normalised dig_sel must be exactly one-hot. Zero or multiple bits set means "no digit"; the settle counter holds at 0.
  - The settle counter clears whenever registered dig_sel differs from its previous value.
  - Otherwise the counter increments and saturates at SETTLE_CYCLES.
  - The sample is taken on the cycle the counter equals SETTLE_CYCLES-1. That gives exactly one capture per strobe; strobes shorter than SETTLE_CYCLES are ignored.
- Segment decode, normalised {G,F,E,D,C,B,A}:
  - Digits: 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D→6, 0x07→7, 0x7F→8, 0x6F→9, 0x67→9.
  - 0x00 (blanked) → 0.
  - Any other pattern → nibble 0xF plus a per-digit bad flag.
- Capture: writes the digit register and bad flag, and sets the mask bit. Recapturing the same digit before the frame completes overwrites it.
- FSM:
  - COLLECT: captures allowed. Move to MUL on the edge after the mask becomes 3'b111.
  - MUL: acc(10b) = hundreds*100, computed as (h<<6)+(h<<5)+(h<<2). Mask cleared.
  - ADD: acc = acc + tens*10 + units, with tens*10 = (t<<3)+(t<<1).
  - DONE:
    - Error case: any bad flag set or acc>255 → frame_err=1; value_out and digits_out hold.
    - Good case: value_out=acc[7:0], digits_out={h,t,u}, value_valid=1.
    - Return to COLLECT next cycle.
  - Captures arriving during MUL/ADD/DONE are dropped. SETTLE_CYCLES≥4 guarantees none are lost in normal scanning.
- Latency: value_valid/frame_err are high in the 3rd cycle after the edge that captures the final digit. Both are exactly 1 cycle wide and never high together.
- Frames are independent: after DONE, all three digits must be captured again before the next result.

Test Plan:
- Driver-style scan of 123 (active-low seg = ~{0x06,0x5B,0x4F}, dig_sel 110/101/011, 64 cycles each) → value_valid pulse; value_out=0x7B; digits_out=0x123; frame_err never high.
- Scan 2,5,5 then 2,5,6 → first frame gives value_out=0xFF. Second frame gives frame_err pulse, value_out stays 0xFF, no value_valid.
- Tens strobe held 10 cycles (SETTLE_CYCLES=16), then dig_sel=000, then a 64-cycle tens strobe showing 4, with units 7 and hundreds 0 → only the long strobe captures; value_out=47.
- Normalised pattern 0x49 on hundreds → frame_err pulse 3 cycles after the last capture; outputs unchanged.
- Raw seg 0x7F (blank) on hundreds and tens, units 8; interleave dig_sel=100 (two digits selected) for 40 cycles → the glitch is ignored; value_out=8.
- rst=1 for 1 cycle while FSM=ADD → no pulse, all outputs 0; next full frame of 9,9,9 → frame_err (999>255); a following 0,4,2 → value_out=42.
